// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word RAM read at accept, LATENCY-cycle pipe, in-order response FIFO.
// Accept-to-FIFO latency LATENCY; credits (in-flight + queued) hold req_ready_o low so the pipe never stalls.
module instr_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_instr_o,
    output logic [31:0] rsp_addr_o,
    output logic        rsp_err_o,
    input  logic        ld_we_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [31:0] DEPTH_U = DEPTH_WORDS;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic               pipe_err_q [LATENCY];
    logic               pipe_err_d [LATENCY];
    logic [31:0]        pipe_addr_q [LATENCY];
    logic [31:0]        pipe_addr_d [LATENCY];
    logic [31:0]        pipe_dat_q [LATENCY];
    logic [31:0]        pipe_dat_d [LATENCY];

    logic [64:0]        fifo_q [FIFO_DEPTH];
    logic [64:0]        fifo_head;
    logic [PW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      credit_q, credit_d;

    logic               req_err, ld_ok, accept, pop, push;
    logic [AW-1:0]      req_idx, ld_idx;
    logic               unused_ld_lsb;

    assign req_err = (req_addr_i[1:0] != 2'b00) | ({2'b00, req_addr_i[31:2]} >= DEPTH_U);
    assign req_idx = req_addr_i[AW+1:2];
    assign ld_idx  = ld_addr_i[AW+1:2];
    assign ld_ok   = ld_we_i & ({2'b00, ld_addr_i[31:2]} < DEPTH_U);
    assign unused_ld_lsb = ^ld_addr_i[1:0];

    assign rsp_valid_o = (wr_ptr_q != rd_ptr_q);
    assign req_ready_o = ~rst_i & ~flush_i & (credit_q < CW'(FIFO_DEPTH));
    assign accept      = req_valid_i & req_ready_o;
    assign pop         = rsp_valid_o & rsp_ready_i & ~flush_i;
    assign push        = pipe_vld_q[LATENCY-1] & ~flush_i;

    // Faults never touch the RAM; the NOP is substituted at the read stage.
    always_comb begin
        pipe_vld_d     = '0;
        pipe_vld_d[0]  = accept;
        pipe_err_d[0]  = req_err;
        pipe_addr_d[0] = req_addr_i;
        pipe_dat_d[0]  = req_err ? NOP : mem_q[req_idx];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_err_d[i]  = pipe_err_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
            pipe_dat_d[i]  = pipe_dat_q[i-1];
        end
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
        credit_d = credit_q + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
        if (flush_i) begin
            pipe_vld_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            credit_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            credit_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_err_q[i]  <= 1'b0;
                pipe_addr_q[i] <= '0;
                pipe_dat_q[i]  <= '0;
            end
        end else begin
            pipe_vld_q <= pipe_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            credit_q   <= credit_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_err_q[i]  <= pipe_err_d[i];
                pipe_addr_q[i] <= pipe_addr_d[i];
                pipe_dat_q[i]  <= pipe_dat_d[i];
            end
        end
    end

    // Storage arrays carry no reset; validity lives in the pointers and pipe valids.
    always_ff @(posedge clk_i) begin
        if (ld_ok) begin
            mem_q[ld_idx] <= ld_data_i;
        end
        if (push) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= {pipe_err_q[LATENCY-1], pipe_addr_q[LATENCY-1],
                                         pipe_dat_q[LATENCY-1]};
        end
    end

    assign fifo_head   = fifo_q[rd_ptr_q[PW-1:0]];
    assign rsp_err_o   = rsp_valid_o & fifo_head[64];
    assign rsp_addr_o  = rsp_valid_o ? fifo_head[63:32] : 32'h0;
    assign rsp_instr_o = rsp_valid_o ? fifo_head[31:0] : 32'h0;
endmodule
